psw_reg: RTL and testbench
==========================

PSW_REG -- requirements
Module: psw_reg

Interface
REQ-001 SHALL have one parameter per line: STK_DEPTH, default 4, depth of the PSW save stack (power of two, 2..8).
REQ-002 SHALL have the port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have the port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have the port: alu_psw  in  16  flag values from the flag-calculation stage (C=0, Z=1, N=2, V=4).
REQ-005 SHALL have the port: alu_msk  in  16  per-bit write mask accompanying alu_psw.
REQ-006 SHALL have the port: alu_we  in  1  commits the masked ALU flag update this cycle.
REQ-007 SHALL have the port: setcc_we  in  1  SETCC request.
REQ-008 SHALL have the port: clrcc_we  in  1  CLRCC request.
REQ-009 SHALL have the port: cc_bits  in  5  {V,SLP,N,Z,C} selector for SETCC/CLRCC.
REQ-010 SHALL have the port: push  in  1  exception entry; save PSW and raise priority.
REQ-011 SHALL have the port: pop  in  1  exception return; restore saved PSW.
REQ-012 SHALL have the port: new_pri  in  3  priority loaded on push.
REQ-013 SHALL have the port: psw_q  out  16  registered PSW.
REQ-014 SHALL have the port: stk_cnt  out  4  number of saved entries.
REQ-015 SHALL have the port: stk_ovf  out  1  sticky, push attempted when full.
REQ-016 SHALL have the port: stk_unf  out  1  sticky, pop attempted when empty.
REQ-017 SHALL have the port: op_err  out  1  one-cycle pulse, push and pop asserted together.

Function
REQ-018 SHALL use the PSW layout: C[0], Z[1], N[2], SLP[3], V[4], CUR_PRI[7:5], FLT[8], bits [12:9] always 0, PREV_PRI[15:13].
REQ-019 SHALL change psw_q only on clk rising edge; it SHALL have no combinational path from any input to psw_q, with one-cycle latency from request to visible PSW.
REQ-020 SHALL apply requests in the priority order reset > push/pop > setcc/clrcc > alu_we; only the highest-priority active request applies, and lower ones are discarded that cycle.
REQ-021 SHALL, on an ALU update, load psw_q <= (psw_q & ~alu_msk) | (alu_psw & alu_msk), with bits [12:9] forced to 0.
REQ-022 SHALL, on SETCC, set each PSW bit selected by cc_bits to 1; on CLRCC, clear each selected bit to 0.
REQ-023 SHALL, when SETCC and CLRCC are asserted together, let CLRCC win for each bit selected by cc_bits.
REQ-024 SHALL, on push when not full, write the pre-update psw_q to stack[stk_cnt] and increment stk_cnt; the next psw_q SHALL have flags C/Z/N/V/SLP = 0, CUR_PRI = new_pri, PREV_PRI = old CUR_PRI, and FLT unchanged.
REQ-025 SHALL, on push when stk_cnt == STK_DEPTH, leave the stack unchanged, set stk_ovf, set FLT, load CUR_PRI = 3'b111, and leave the other PSW bits unchanged.
REQ-026 SHALL, on pop when not empty, load psw_q from stack[stk_cnt-1] and decrement stk_cnt.
REQ-027 SHALL, on pop when stk_cnt == 0, leave psw_q and the stack unchanged and set stk_unf.
REQ-028 SHALL, when push and pop are asserted together, perform neither operation, leave psw_q unchanged, and pulse op_err high for one cycle; setcc/clrcc/alu_we SHALL be discarded that cycle.
REQ-029 SHALL keep stk_ovf and stk_unf set until reset.
REQ-030 SHALL let stk_cnt count from 0 to STK_DEPTH without wrap-around.

Reset
REQ-031 SHALL, on reset, drive psw_q = 16'h00E0 (CUR_PRI = 7, all else 0), stk_cnt = 0, stk_ovf = 0, stk_unf = 0, op_err = 0.
REQ-032 SHALL let reset asserted mid-push or mid-pop override the operation; stack contents are don't-care after reset.

Configuration
REQ-033 SHALL implement the save stack only when macro PSW_STACK_EN is defined.
REQ-034 SHALL, with PSW_STACK_EN undefined, ignore push and pop, hold stk_cnt/stk_ovf/stk_unf/op_err at 0, and keep ALU/SETCC/CLRCC behaviour unchanged.

Verification
REQ-035 SHALL cover: after reset, alu_we=1, alu_psw=16'h0013, alu_msk=16'h0017 -> next cycle psw_q=16'h00F3.
REQ-036 SHALL cover: psw_q=16'h00E0, setcc_we=1 and clrcc_we=1, cc_bits=5'b00011 -> psw_q=16'h00E0; setcc alone with cc_bits=5'b10001 -> 16'h00F1.
REQ-037 SHALL cover: psw_q=16'h0071 (CUR_PRI=3), push with new_pri=5 -> psw_q=16'h60A0, stk_cnt=1; then pop -> psw_q=16'h0071, stk_cnt=0.
REQ-038 SHALL cover: 4 pushes then a 5th push -> stk_ovf=1, FLT=1, CUR_PRI=7, stk_cnt=4.
REQ-039 SHALL cover: pop at stk_cnt=0 -> stk_unf=1, psw_q unchanged; push and pop together with alu_we=1 -> op_err one-cycle pulse, psw_q unchanged.
REQ-040 SHALL cover: reset asserted in the same cycle as push -> psw_q=16'h00E0, stk_cnt=0.

Source files
------------

// File: rtl/psw_reg.sv
// Processor status word register with optional exception save stack.
// The save stack and its status outputs exist only when PSW_STACK_EN is defined.
module psw_reg #(
    parameter int STK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] alu_psw,
    input  logic [15:0] alu_msk,
    input  logic        alu_we,
    input  logic        setcc_we,
    input  logic        clrcc_we,
    input  logic [4:0]  cc_bits,
    input  logic        push,
    input  logic        pop,
    input  logic [2:0]  new_pri,
    output logic [15:0] psw_q,
    output logic [3:0]  stk_cnt,
    output logic        stk_ovf,
    output logic        stk_unf,
    output logic        op_err
);

    localparam logic [15:0] PSW_RST  = 16'h00E0;
    // Bits [12:9] do not exist in the PSW and always read as zero.
    localparam logic [15:0] PSW_LIVE = 16'hE1FF;

    logic [15:0] psw_r;
    logic [15:0] cc_msk;

    assign psw_q  = psw_r;
    assign cc_msk = {11'd0, cc_bits};

    function automatic logic [15:0] cc_apply(input logic [15:0] p, input logic set_en,
                                             input logic clr_en, input logic [15:0] m);
        logic [15:0] r;
        r = p;
        if (set_en) r = r | m;
        if (clr_en) r = r & ~m;
        return r;
    endfunction

    function automatic logic [15:0] alu_merge(input logic [15:0] p, input logic [15:0] a,
                                              input logic [15:0] m);
        return ((p & ~m) | (a & m)) & PSW_LIVE;
    endfunction

`ifdef PSW_STACK_EN
    localparam int          IW    = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    localparam logic [3:0]  DEPTH = 4'(STK_DEPTH);

    logic [15:0]   stk [STK_DEPTH];
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_m1;
    logic          ovf_r;
    logic          unf_r;
    logic          err_r;
    logic          full;
    logic          empty;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full    = (cnt_r == DEPTH);
    assign empty   = (cnt_r == 4'd0);
    assign cnt_m1  = cnt_r - 4'd1;
    assign wr_idx  = cnt_r[IW-1:0];
    assign rd_idx  = cnt_m1[IW-1:0];
    assign stk_cnt = cnt_r;
    assign stk_ovf = ovf_r;
    assign stk_unf = unf_r;
    assign op_err  = err_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            psw_r <= PSW_RST;
            cnt_r <= 4'd0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            err_r <= push & pop;
            if (push && pop) begin
                psw_r <= psw_r;
            end else if (push) begin
                if (full) begin
                    // Overflow: flag the fault and mask everything at top priority.
                    ovf_r <= 1'b1;
                    psw_r <= psw_r | 16'h01E0;
                end else begin
                    cnt_r <= cnt_r + 4'd1;
                    psw_r <= {psw_r[7:5], 4'b0000, psw_r[8], new_pri, 5'b00000};
                end
            end else if (pop) begin
                if (empty) begin
                    unf_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_m1;
                    psw_r <= stk[rd_idx];
                end
            end else if (setcc_we || clrcc_we) begin
                psw_r <= cc_apply(psw_r, setcc_we, clrcc_we, cc_msk);
            end else if (alu_we) begin
                psw_r <= alu_merge(psw_r, alu_psw, alu_msk);
            end
        end
    end

    // Stack storage carries no reset; its contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (!reset && push && !pop && !full) begin
            stk[wr_idx] <= psw_r;
        end
    end
`else
    logic unused_stack_ins;
    assign unused_stack_ins = ^{push, pop, new_pri};

    assign stk_cnt = 4'd0;
    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
    assign op_err  = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            psw_r <= PSW_RST;
        end else if (setcc_we || clrcc_we) begin
            psw_r <= cc_apply(psw_r, setcc_we, clrcc_we, cc_msk);
        end else if (alu_we) begin
            psw_r <= alu_merge(psw_r, alu_psw, alu_msk);
        end
    end
`endif

endmodule

// File: tb/tb_psw_reg.sv
// Directed self-checking bench for psw_reg; expectations adapt to whether
// PSW_STACK_EN is defined for the build.
module tb_psw_reg;

`ifdef PSW_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_psw;
    logic [15:0] alu_msk;
    logic        alu_we;
    logic        setcc_we;
    logic        clrcc_we;
    logic [4:0]  cc_bits;
    logic        push;
    logic        pop;
    logic [2:0]  new_pri;
    logic [15:0] psw_q;
    logic [3:0]  stk_cnt;
    logic        stk_ovf;
    logic        stk_unf;
    logic        op_err;

    int n_chk  = 0;
    int n_fail = 0;

    psw_reg #(.STK_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .alu_psw  (alu_psw),
        .alu_msk  (alu_msk),
        .alu_we   (alu_we),
        .setcc_we (setcc_we),
        .clrcc_we (clrcc_we),
        .cc_bits  (cc_bits),
        .push     (push),
        .pop      (pop),
        .new_pri  (new_pri),
        .psw_q    (psw_q),
        .stk_cnt  (stk_cnt),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf),
        .op_err   (op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        alu_we   = 1'b0;
        setcc_we = 1'b0;
        clrcc_we = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
    endtask

    task automatic do_push(input logic [2:0] pri);
        push    = 1'b1;
        new_pri = pri;
        tick();
        idle();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        alu_psw = 16'h0;
        alu_msk = 16'h0;
        cc_bits = 5'd0;
        new_pri = 3'd0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_psw", psw_q, 16'h00E0);
        chk("rst_cnt", 16'(stk_cnt), 16'd0);
        chk("rst_ovf", 16'(stk_ovf), 16'd0);
        chk("rst_unf", 16'(stk_unf), 16'd0);
        chk("rst_err", 16'(op_err), 16'd0);

        alu_we = 1'b1; alu_psw = 16'h0013; alu_msk = 16'h0017;
        tick(); idle();
        chk("alu_masked", psw_q, 16'h00F3);

        reset = 1'b1; tick(); idle();
        chk("rst_again", psw_q, 16'h00E0);

        setcc_we = 1'b1; clrcc_we = 1'b1; cc_bits = 5'b00011;
        tick(); idle();
        chk("set_clr_both", psw_q, 16'h00E0);

        setcc_we = 1'b1; cc_bits = 5'b10001;
        tick(); idle();
        chk("setcc_vc", psw_q, 16'h00F1);

        // SETCC outranks a simultaneous ALU write.
        setcc_we = 1'b1; cc_bits = 5'b00100;
        alu_we = 1'b1; alu_psw = 16'h0000; alu_msk = 16'hFFFF;
        tick(); idle();
        chk("setcc_over_alu", psw_q, 16'h00F5);

        clrcc_we = 1'b1; cc_bits = 5'b11111;
        tick(); idle();
        chk("clrcc_all", psw_q, 16'h00E0);

        alu_we = 1'b1; alu_psw = 16'hFFFF; alu_msk = 16'hFFFF;
        tick(); idle();
        chk("alu_hole_zero", psw_q, 16'hE1FF);

        alu_we = 1'b1; alu_psw = 16'h0071; alu_msk = 16'hFFFF;
        tick(); idle();
        chk("alu_load", psw_q, 16'h0071);

        do_push(3'd5);
        chk("push1_psw", psw_q, STK ? 16'h60A0 : 16'h0071);
        chk("push1_cnt", 16'(stk_cnt), STK ? 16'd1 : 16'd0);
        do_pop();
        chk("pop1_psw", psw_q, 16'h0071);
        chk("pop1_cnt", 16'(stk_cnt), 16'd0);

        do_push(3'd1);
        chk("fill1", psw_q, STK ? 16'h6020 : 16'h0071);
        do_push(3'd2);
        chk("fill2", psw_q, STK ? 16'h2040 : 16'h0071);
        do_push(3'd3);
        chk("fill3", psw_q, STK ? 16'h4060 : 16'h0071);
        do_push(3'd4);
        chk("fill4", psw_q, STK ? 16'h6080 : 16'h0071);
        chk("fill_cnt", 16'(stk_cnt), STK ? 16'd4 : 16'd0);
        chk("fill_ovf", 16'(stk_ovf), 16'd0);
        do_push(3'd2);
        chk("ovf_psw", psw_q, STK ? 16'h61E0 : 16'h0071);
        chk("ovf_cnt", 16'(stk_cnt), STK ? 16'd4 : 16'd0);
        chk("ovf_flag", 16'(stk_ovf), STK ? 16'd1 : 16'd0);

        do_pop();
        chk("unwind4", psw_q, STK ? 16'h4060 : 16'h0071);
        chk("unwind4_cnt", 16'(stk_cnt), STK ? 16'd3 : 16'd0);
        do_pop();
        chk("unwind3", psw_q, STK ? 16'h2040 : 16'h0071);
        do_pop();
        chk("unwind2", psw_q, STK ? 16'h6020 : 16'h0071);
        do_pop();
        chk("unwind1", psw_q, 16'h0071);
        chk("unwind_cnt", 16'(stk_cnt), 16'd0);
        chk("unwind_unf", 16'(stk_unf), 16'd0);

        do_pop();
        chk("unf_psw", psw_q, 16'h0071);
        chk("unf_flag", 16'(stk_unf), STK ? 16'd1 : 16'd0);
        chk("unf_cnt", 16'(stk_cnt), 16'd0);

        // Push and pop together: with the stack, nothing changes and op_err pulses.
        push = 1'b1; pop = 1'b1; new_pri = 3'd6;
        alu_we = 1'b1; alu_psw = 16'h0000; alu_msk = 16'hFFFF;
        tick(); idle();
        chk("pp_err", 16'(op_err), STK ? 16'd1 : 16'd0);
        chk("pp_psw", psw_q, STK ? 16'h0071 : 16'h0000);
        chk("pp_cnt", 16'(stk_cnt), 16'd0);
        tick();
        chk("pp_err_drop", 16'(op_err), 16'd0);
        chk("ovf_sticky", 16'(stk_ovf), STK ? 16'd1 : 16'd0);
        chk("unf_sticky", 16'(stk_unf), STK ? 16'd1 : 16'd0);

        alu_we = 1'b1; alu_psw = 16'h0015; alu_msk = 16'hFFFF;
        tick(); idle();
        do_push(3'd2);
        chk("pre_rst_push", psw_q, STK ? 16'h0040 : 16'h0015);
        reset = 1'b1; push = 1'b1; new_pri = 3'd3;
        tick(); idle();
        chk("rst_push_psw", psw_q, 16'h00E0);
        chk("rst_push_cnt", 16'(stk_cnt), 16'd0);
        chk("rst_push_ovf", 16'(stk_ovf), 16'd0);
        chk("rst_push_unf", 16'(stk_unf), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
